// File: rtl/get_legendre_segment_barrel_mul_pipe.sv
// Pipelined multiplier with independent operand signedness, optional round/shift,
// saturation to the output width and overflow flag, behind a bubble-collapsing valid/ready pipe.
module get_legendre_segment_barrel_mul_pipe #(
  parameter int unsigned A_WIDTH   = 13,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned A_SIGNED  = 0,
  parameter int unsigned B_SIGNED  = 1,
  parameter int unsigned P_WIDTH   = 31,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_WIDTH-1:0]   out_p,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_ovf
);

  localparam int unsigned PW         = A_WIDTH + B_WIDTH + 1;
  localparam int unsigned RW         = PW + 1;
  localparam bit          RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam logic signed [RW-1:0] ONE  = RW'(1);
  localparam logic signed [RW-1:0] HALF = (ONE <<< SHIFT) >>> 1;
  localparam logic signed [RW-1:0] SMAX = (ONE <<< (P_WIDTH - 1)) - ONE;
  localparam logic signed [RW-1:0] SMIN = -(ONE <<< (P_WIDTH - 1));
  localparam logic signed [RW-1:0] UMAX = (ONE <<< P_WIDTH) - ONE;

  logic [NUM_STAGE-1:0] vld_q, vld_d, ld, src_v;

  // A stage loads when it, or any stage downstream of it, is empty, or the output drains.
  always_comb begin
    src_v = NUM_STAGE'({vld_q, in_valid});
    ld    = '0;
    vld_d = vld_q;
    for (int unsigned k = 0; k < NUM_STAGE; k++) begin
      ld[k] = out_ready;
      for (int unsigned j = k; j < NUM_STAGE; j++) begin
        if (!vld_q[j]) ld[k] = 1'b1;
      end
      vld_d[k] = ld[k] ? src_v[k] : vld_q[k];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[NUM_STAGE-1];

  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [TAG_WIDTH-1:0] tag0_q, tag0_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    tag0_d = tag0_q;
    if (ld[0] && in_valid) begin
      a_d    = in_a;
      b_d    = in_b;
      tag0_d = in_tag;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag0_q <= '0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      tag0_q <= tag0_d;
    end
  end

  logic signed [PW-1:0] a_ext, b_ext, prod;
  logic signed [RW-1:0] rnd, sat;
  logic [P_WIDTH-1:0]   calc_p;
  logic                 calc_ovf;

  always_comb begin
    a_ext    = {{(PW - A_WIDTH){(A_SIGNED != 0) && a_q[A_WIDTH-1]}}, a_q};
    b_ext    = {{(PW - B_WIDTH){(B_SIGNED != 0) && b_q[B_WIDTH-1]}}, b_q};
    prod     = a_ext * b_ext;
    rnd      = (RW'(prod) + HALF) >>> SHIFT;
    sat      = rnd;
    calc_ovf = 1'b0;
    if (RES_SIGNED) begin
      if (rnd > SMAX) begin
        sat      = SMAX;
        calc_ovf = 1'b1;
      end else if (rnd < SMIN) begin
        sat      = SMIN;
        calc_ovf = 1'b1;
      end
    end else begin
      if (rnd > UMAX) begin
        sat      = UMAX;
        calc_ovf = 1'b1;
      end else if (rnd < 0) begin
        sat      = '0;
        calc_ovf = 1'b1;
      end
    end
    calc_p = sat[P_WIDTH-1:0];
  end

  // Single-stage pipe: result is formed combinationally from the captured operands.
  if (NUM_STAGE == 1) begin : g_single
    assign out_p   = calc_p;
    assign out_tag = tag0_q;
    assign out_ovf = calc_ovf;
  end else begin : g_multi
    logic [P_WIDTH-1:0]   p_q   [1:NUM_STAGE-1];
    logic [P_WIDTH-1:0]   p_d   [1:NUM_STAGE-1];
    logic [TAG_WIDTH-1:0] tag_q [1:NUM_STAGE-1];
    logic [TAG_WIDTH-1:0] tag_d [1:NUM_STAGE-1];
    logic                 ovf_q [1:NUM_STAGE-1];
    logic                 ovf_d [1:NUM_STAGE-1];

    always_comb begin
      p_d   = p_q;
      tag_d = tag_q;
      ovf_d = ovf_q;
      if (ld[1] && vld_q[0]) begin
        p_d[1]   = calc_p;
        tag_d[1] = tag0_q;
        ovf_d[1] = calc_ovf;
      end
      for (int unsigned k = 2; k < NUM_STAGE; k++) begin
        if (ld[k] && vld_q[k-1]) begin
          p_d[k]   = p_q[k-1];
          tag_d[k] = tag_q[k-1];
          ovf_d[k] = ovf_q[k-1];
        end
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int unsigned k = 1; k < NUM_STAGE; k++) begin
          p_q[k]   <= '0;
          tag_q[k] <= '0;
          ovf_q[k] <= 1'b0;
        end
      end else begin
        p_q   <= p_d;
        tag_q <= tag_d;
        ovf_q <= ovf_d;
      end
    end

    assign out_p   = p_q[NUM_STAGE-1];
    assign out_tag = tag_q[NUM_STAGE-1];
    assign out_ovf = ovf_q[NUM_STAGE-1];
  end

endmodule

// File: tb/tb_get_legendre_segment_barrel_mul_pipe.sv
// Scoreboard bench: five parameter sets covering all operand signedness combinations,
// directed, backpressure, random valid/ready and mid-stream reset traffic.
module tb_get_legendre_segment_barrel_mul_pipe;

  localparam int NCFG  = 5;
  localparam int NRAND = 2000;

  localparam int C_AW [NCFG] = '{13, 13, 8, 13, 13};
  localparam int C_BW [NCFG] = '{18, 18, 8, 18, 18};
  localparam int C_AS [NCFG] = '{0, 0, 0, 1, 1};
  localparam int C_BS [NCFG] = '{1, 1, 0, 1, 0};
  localparam int C_PW [NCFG] = '{31, 16, 8, 20, 12};
  localparam int C_SH [NCFG] = '{0, 4, 0, 7, 3};
  localparam int C_NS [NCFG] = '{3, 3, 3, 2, 1};

  localparam int     D_N [NCFG]    = '{1, 5, 2, 4, 3};
  localparam longint D_A [NCFG][5] = '{'{8191, 0, 0, 0, 0}, '{100, 3, 1, 8191, 8191},
                                       '{255, 15, 0, 0, 0}, '{-4096, -1, 1, 1, 0},
                                       '{-4096, 5, -5, 0, 0}};
  localparam longint D_B [NCFG][5] = '{'{-131072, 0, 0, 0, 0}, '{3, -8, -8, 131071, -131072},
                                       '{255, 15, 0, 0, 0}, '{-131072, -64, -64, -65, 0},
                                       '{131071, 3, 3, 0, 0}};
  localparam longint D_P [NCFG][5] = '{'{-1073610752, 0, 0, 0, 0}, '{19, -1, 0, 32767, -32768},
                                       '{255, 225, 0, 0, 0}, '{524287, 1, 0, -1, 0},
                                       '{-2048, 2, -2, 0, 0}};
  localparam int     D_O [NCFG][5] = '{'{0, 0, 0, 0, 0}, '{0, 0, 0, 1, 1},
                                       '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}};

  typedef struct {
    longint     p;
    bit         ovf;
    logic [7:0] tag;
    int         cyc;
    bit         lat;
  } item_t;

  logic            clk;
  int              cyc;
  int              n_vec;
  int              n_bad;
  logic [NCFG-1:0] done_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer product, round half up, floor shift, clamp.
  function automatic void ref_model(input int aw, input int bw, input int asg, input int bsg,
                                    input int pw, input int sh, input longint ar,
                                    input longint br, output longint p, output bit ovf);
    longint av, bv, r, hi, lo;
    av = (asg != 0 && ar[aw-1]) ? ar - (longint'(1) <<< aw) : ar;
    bv = (bsg != 0 && br[bw-1]) ? br - (longint'(1) <<< bw) : br;
    r  = av * bv;
    if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
    if (asg != 0 || bsg != 0) begin
      hi = (longint'(1) <<< (pw - 1)) - 1;
      lo = -(longint'(1) <<< (pw - 1));
    end else begin
      hi = (longint'(1) <<< pw) - 1;
      lo = 0;
    end
    p   = r;
    ovf = 1'b0;
    if (r > hi) begin
      p   = hi;
      ovf = 1'b1;
    end else if (r < lo) begin
      p   = lo;
      ovf = 1'b1;
    end
  endfunction

  function automatic longint rnd_op(input int w);
    longint m;
    m = (longint'(1) <<< w) - 1;
    case ($urandom_range(0, 4))
      0:       return m;
      1:       return longint'(1) <<< (w - 1);
      2:       return 0;
      default: return longint'($urandom) & m;
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int AW = C_AW[g];
    localparam int BW = C_BW[g];
    localparam int PW = C_PW[g];
    localparam int NS = C_NS[g];

    logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic [7:0]    in_tag, out_tag;
    logic [PW-1:0] out_p;
    int            rdy_mode;
    item_t         sb[$];
    bit            fin;

    assign done_v[g] = fin;

    get_legendre_segment_barrel_mul_pipe #(
      .A_WIDTH(AW), .B_WIDTH(BW), .A_SIGNED(C_AS[g]), .B_SIGNED(C_BS[g]),
      .P_WIDTH(PW), .SHIFT(C_SH[g]), .NUM_STAGE(NS), .TAG_WIDTH(8)
    ) u_dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag), .out_ovf(out_ovf)
    );

    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = 1'b0;
        endcase
      end
    end

    initial begin
      item_t         it;
      logic [PW-1:0] ep;
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL cfg%0d unexpected_beat: got p=%0h tag=%0h, want no beat", g, out_p, out_tag);
          end else begin
            it = sb.pop_front();
            ep = PW'(it.p);
            if (out_p !== ep || out_tag !== it.tag || out_ovf !== it.ovf) begin
              n_bad++;
              $display("FAIL cfg%0d beat: got p=%0h tag=%0h ovf=%0b, want p=%0h tag=%0h ovf=%0b",
                       g, out_p, out_tag, out_ovf, ep, it.tag, it.ovf);
            end
            if (it.lat) begin
              n_vec++;
              if (cyc - it.cyc != NS) begin
                n_bad++;
                $display("FAIL cfg%0d latency: got %0d, want %0d", g, cyc - it.cyc, NS);
              end
            end
          end
        end
      end
    end

    task automatic try_offer(input longint a, input longint b, input logic [7:0] tag,
                             input longint ep, input bit eo, input bit lat, output bit acc);
      item_t it;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = AW'(a);
      in_b     = BW'(b);
      in_tag   = tag;
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        it.p = ep; it.ovf = eo; it.tag = tag; it.cyc = cyc; it.lat = lat;
        sb.push_back(it);
      end
    endtask

    task automatic offer(input longint a, input longint b, input logic [7:0] tag,
                         input longint ep, input bit eo, input bit lat);
      bit acc;
      for (int n = 0; n < 300; n++) begin
        try_offer(a, b, tag, ep, eo, lat, acc);
        if (acc) return;
      end
      n_vec++;
      n_bad++;
      $display("FAIL cfg%0d accept_timeout: got in_ready=0 for 300 cycles, want 1", g);
    endtask

    task automatic rand_offer(input logic [7:0] tag, output bit acc);
      longint ar, br, ep;
      bit     eo;
      ar = rnd_op(AW);
      br = rnd_op(BW);
      ref_model(AW, BW, C_AS[g], C_BS[g], PW, C_SH[g], ar, br, ep, eo);
      try_offer(ar, br, tag, ep, eo, 1'b0, acc);
    endtask

    task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
        @(posedge clk);
        n++;
      end
      n_vec++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL cfg%0d drain: got %0d beats pending, want 0", g, sb.size());
      end
    endtask

    initial begin
      bit acc;
      int nt, acc_n, got;
      fin      = 1'b0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_tag   = '0;
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_p !== '0 || out_tag !== 8'h00 || out_ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL cfg%0d reset_state: got v=%0b p=%0h tag=%0h ovf=%0b, want all 0",
                 g, out_valid, out_p, out_tag, out_ovf);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL cfg%0d ready_after_reset: got %0b, want 1", g, in_ready);
      end

      for (int i = 0; i < D_N[g]; i++)
        offer(D_A[g][i], D_B[g][i], 8'(8'h5A + i), D_P[g][i], D_O[g][i] != 0, 1'b1);
      idle();
      drain();

      rdy_mode = 2;
      idle();
      nt    = 1;
      acc_n = 0;
      for (int c = 0; c < 6; c++) begin
        rand_offer(8'(nt), acc);
        if (acc) begin
          nt++;
          acc_n++;
        end
      end
      n_vec++;
      if (acc_n != NS || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL cfg%0d backpressure: got accepted=%0d in_ready=%0b, want accepted=%0d in_ready=0",
                 g, acc_n, in_ready, NS);
      end
      rdy_mode = 0;
      got      = 0;
      for (int c = 0; c < 6; c++) begin
        if (nt <= 6) begin
          rand_offer(8'(nt), acc);
          if (acc) nt++;
        end else begin
          idle();
          @(negedge clk);
        end
        if (out_valid) got++;
      end
      n_vec++;
      if (got != 6) begin
        n_bad++;
        $display("FAIL cfg%0d release_stream: got %0d valid cycles, want 6", g, got);
      end
      idle();
      drain();

      rdy_mode = 1;
      for (int i = 0; i < NRAND; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        acc = 1'b0;
        for (int n = 0; n < 300 && !acc; n++) rand_offer(i[7:0], acc);
        if (!acc) begin
          n_vec++;
          n_bad++;
          $display("FAIL cfg%0d random_accept: got no accept in 300 cycles, want accept", g);
        end
      end
      rdy_mode = 0;
      idle();
      drain();

      rdy_mode = 2;
      idle();
      acc_n = 0;
      for (int c = 0; c < 6 && acc_n < 3; c++) begin
        rand_offer(8'(8'hC0 + c), acc);
        if (acc) acc_n++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_p !== '0 || out_tag !== 8'h00) begin
        n_bad++;
        $display("FAIL cfg%0d midstream_reset: got v=%0b p=%0h tag=%0h, want v=0 p=0 tag=0",
                 g, out_valid, out_p, out_tag);
      end
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      repeat (2 * NS + 6) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int n = 0; n < 60000; n++) begin
      @(posedge clk);
      if (&done_v) break;
    end
    if (!(&done_v)) begin
      n_vec++;
      n_bad++;
      $display("FAIL global_timeout: got done=%b, want all set", done_v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
